vec_ram_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one two-read/one-write vector RAM (2048 × `Vector_t`, per-element write strobe, 1-cycle registered read) among `NUM_REQ` requesters. Each requester issues dual-operand read requests and strobed write requests over valid/ready handshakes. The block resolves same-cycle read/write address collisions with a fixed ordering rule and a starvation guard, and broadcasts tagged read responses. It sits between the vector-lane issue logic and the RAM instance.

---
 rtl/vec_ram_arbiter_pkg.sv | 16 +
 rtl/vec_ram_arbiter_rr.sv | 34 +++
 rtl/vec_ram_arbiter.sv | 119 +++++++++++
 tb/tb_vec_ram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_ram_arbiter_pkg.sv
// Shared vector types and RAM geometry for the vector-RAM arbiter slice.
// A vector is VEC_LEN elements of ELEM_W bits; element 0 sits in the low bits.
package vec_ram_arbiter_pkg;

    localparam int ELEM_W      = 8;
    localparam int VEC_LEN     = 8;
    localparam int VEC_WIDTH   = ELEM_W * VEC_LEN;
    localparam int RAM_SIZE    = 2048;
    localparam int RAM_ADDR_W  = $clog2(RAM_SIZE);
    localparam int NUM_REQ_DEF = 4;

    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] Vector_t;
    typedef logic [VEC_LEN-1:0]             Mask_t;
    typedef logic [$clog2(NUM_REQ_DEF)-1:0] ReqId_t;

endpackage

// File: rtl/vec_ram_arbiter_rr.sv
// Round-robin candidate search starting at ptr; the grant is the candidate
// qualified by en, so the candidate index never depends on en (no comb loop).
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan farthest-first so the last hit is the one closest to ptr.
    always_comb begin
        any = 1'b0;
        idx = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[IW'(ptr + IW'(i))]) begin
                any = 1'b1;
                idx = IW'(ptr + IW'(i));
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vec_ram_arbiter.sv
// Shares one 2R/1W vector RAM among NUM_REQ requesters: independent read and
// write round-robin, read-first collision ordering with a one-shot write starvation guard.
module vec_ram_arbiter
    import vec_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 2048,
    parameter int SIZE_L  = $clog2(SIZE),
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               rd_valid,
    output logic [NUM_REQ-1:0]               rd_ready,
    input  logic [NUM_REQ-1:0][SIZE_L-1:0]   rd_addr0,
    input  logic [NUM_REQ-1:0][SIZE_L-1:0]   rd_addr1,
    input  logic [NUM_REQ-1:0]               wr_valid,
    output logic [NUM_REQ-1:0]               wr_ready,
    input  logic [NUM_REQ-1:0][SIZE_L-1:0]   wr_addr,
    input  Vector_t [NUM_REQ-1:0]            wr_data,
    input  Mask_t [NUM_REQ-1:0]              wr_strb,
    output logic                             rsp_valid,
    output logic [ID_W-1:0]                  rsp_id,
    output Vector_t                          rsp_d0,
    output Vector_t                          rsp_d1,
    output logic [SIZE_L-1:0]                ram_addr0,
    output logic [SIZE_L-1:0]                ram_addr1,
    output logic [SIZE_L-1:0]                ram_waddr,
    output Vector_t                          ram_din,
    output Mask_t                            ram_strb,
    output logic                             ram_wen,
    input  Vector_t                          ram_d0,
    input  Vector_t                          ram_d1
);

    logic [ID_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0] wr_ptr_q, wr_ptr_d;
    logic            wr_starve_q, wr_starve_d;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;

    logic            rd_any, wr_any;
    logic [ID_W-1:0] rd_idx, wr_idx;
    logic            rd_en, wr_en;
    logic            rd_gnt_any, wr_gnt_any;
    logic            collision;

    assign collision = rd_any && wr_any &&
                       ((rd_addr0[rd_idx] == wr_addr[wr_idx]) ||
                        (rd_addr1[rd_idx] == wr_addr[wr_idx]));

    // On a collision exactly one side yields: the write by default, the read once the write has starved.
    assign rd_en = rst_n && !(collision && wr_starve_q);
    assign wr_en = rst_n && !(collision && !wr_starve_q);

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .req (rd_valid),
        .ptr (rd_ptr_q),
        .en  (rd_en),
        .gnt (rd_ready),
        .any (rd_any),
        .idx (rd_idx)
    );

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req (wr_valid),
        .ptr (wr_ptr_q),
        .en  (wr_en),
        .gnt (wr_ready),
        .any (wr_any),
        .idx (wr_idx)
    );

    assign rd_gnt_any = |rd_ready;
    assign wr_gnt_any = |wr_ready;

    // Power-of-two NUM_REQ makes the +1 wrap naturally at ID_W bits.
    always_comb begin
        rd_ptr_d    = rd_gnt_any ? ID_W'(rd_idx + 1'b1) : rd_ptr_q;
        wr_ptr_d    = wr_gnt_any ? ID_W'(wr_idx + 1'b1) : wr_ptr_q;
        wr_starve_d = wr_starve_q;
        if (wr_gnt_any) begin
            wr_starve_d = 1'b0;
        end else if (collision && rd_gnt_any) begin
            wr_starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wr_starve_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_starve_q <= wr_starve_d;
            rsp_valid_q <= rd_gnt_any;
            if (rd_gnt_any) begin
                rsp_id_q <= rd_idx;
            end
        end
    end

    assign ram_addr0 = rd_addr0[rd_idx];
    assign ram_addr1 = rd_addr1[rd_idx];
    assign ram_waddr = wr_addr[wr_idx];
    assign ram_din   = wr_data[wr_idx];
    assign ram_strb  = wr_strb[wr_idx];
    assign ram_wen   = wr_gnt_any;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_d0    = ram_d0;
    assign rsp_d1    = ram_d1;

endmodule

// File: tb/tb_vec_ram_arbiter.sv
// Directed bench for vec_ram_arbiter with a behavioural read-first,
// strobed-write RAM attached to the ram_* port.
module tb_vec_ram_arbiter;
    import vec_ram_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int AW = 11;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NR-1:0]            rd_valid;
    logic [NR-1:0]            rd_ready;
    logic [NR-1:0][AW-1:0]    rd_addr0;
    logic [NR-1:0][AW-1:0]    rd_addr1;
    logic [NR-1:0]            wr_valid;
    logic [NR-1:0]            wr_ready;
    logic [NR-1:0][AW-1:0]    wr_addr;
    Vector_t [NR-1:0]         wr_data;
    Mask_t [NR-1:0]           wr_strb;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    Vector_t                  rsp_d0, rsp_d1;
    logic [AW-1:0]            ram_addr0, ram_addr1, ram_waddr;
    Vector_t                  ram_din;
    Mask_t                    ram_strb;
    logic                     ram_wen;
    Vector_t                  ram_d0, ram_d1;

    Vector_t mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    localparam Vector_t VEC_A   = 64'hA7A6A5A4A3A2A1A0;
    localparam Vector_t VEC_B   = 64'hB7B6B5B4B3B2B1B0;
    localparam Vector_t VEC_MIX = 64'hB7B6B5B4A3A2A1A0;
    localparam Vector_t VEC_C   = 64'hC7C6C5C4C3C2C1C0;
    localparam Vector_t VEC_D   = 64'hD7D6D5D4D3D2D1D0;

    vec_ram_arbiter #(.NUM_REQ(NR), .SIZE(2048)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr0  (rd_addr0),
        .rd_addr1  (rd_addr1),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_d0    (rsp_d0),
        .rsp_d1    (rsp_d1),
        .ram_addr0 (ram_addr0),
        .ram_addr1 (ram_addr1),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_strb  (ram_strb),
        .ram_wen   (ram_wen),
        .ram_d0    (ram_d0),
        .ram_d1    (ram_d1)
    );

    always #5 clk = ~clk;

    // Read-first RAM: reads sample the array before this edge's write lands.
    always @(posedge clk) begin
        ram_d0 <= mem[ram_addr0];
        ram_d1 <= mem[ram_addr1];
        if (ram_wen) begin
            for (int e = 0; e < VEC_LEN; e++) begin
                if (ram_strb[e]) mem[ram_waddr][e] <= ram_din[e];
            end
        end
    end

    function automatic Vector_t pattern(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {8{b}} ^ 64'h0123456789ABCDEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        rd_valid = '0;
        wr_valid = '0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rd_valid = 4'b1111;
        wr_valid = 4'b1111;
        wr_addr[0] = 11'd50;
        #2;
        n_checks++;
        if (rd_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_ready: got %b expected 0000", rd_ready); end
        n_checks++;
        if (wr_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0000", wr_ready); end
        n_checks++;
        if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wen: got %b expected 0", ram_wen); end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp: got valid=%b id=%0d expected valid=0 id=0", rsp_valid, rsp_id); end
        clear_reqs();
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        $display("txn reset: done");
    endtask

    task automatic test_single_read();
        rd_valid[2] = 1'b1;
        rd_addr0[2] = 11'd5;
        rd_addr1[2] = 11'd9;
        #1;
        n_checks++;
        if (rd_ready !== 4'b0100) begin n_fail++; $display("FAIL single_rd_gnt: got %b expected 0100", rd_ready); end
        n_checks++;
        if (ram_addr0 !== 11'd5 || ram_addr1 !== 11'd9) begin n_fail++; $display("FAIL single_ram_addr: got %0d/%0d expected 5/9", ram_addr0, ram_addr1); end
        tick();
        clear_reqs();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp: got valid=%b id=%0d expected valid=1 id=2", rsp_valid, rsp_id); end
        n_checks++;
        if (rsp_d0 !== pattern(5) || rsp_d1 !== pattern(9)) begin n_fail++; $display("FAIL single_rsp_data: got %h/%h expected %h/%h", rsp_d0, rsp_d1, pattern(5), pattern(9)); end
        $display("txn single_read: id=%0d d0=%h d1=%h", rsp_id, rsp_d0, rsp_d1);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int         r;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        rd_valid = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            rd_addr0[i] = AW'(16 + i);
            rd_addr1[i] = AW'(32 + i);
        end
        for (int k = 0; k < 5; k++) begin
            r = k % NR;
            exp_gnt = 4'b0001 << r;
            #1;
            n_checks++;
            if (rd_ready !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b expected %b", k, rd_ready, exp_gnt); end
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(r)) begin n_fail++; $display("FAIL rr_rsp_%0d: got valid=%b id=%0d expected valid=1 id=%0d", k, rsp_valid, rsp_id, r); end
            n_checks++;
            if (rsp_d0 !== pattern(16 + r) || rsp_d1 !== pattern(32 + r)) begin n_fail++; $display("FAIL rr_data_%0d: got %h/%h expected %h/%h", k, rsp_d0, rsp_d1, pattern(16 + r), pattern(32 + r)); end
            $display("txn round_robin[%0d]: id=%0d d0=%h", k, rsp_id, rsp_d0);
        end
        clear_reqs();
    endtask

    task automatic test_write_then_read();
        mem[7] = VEC_B;
        wr_valid[1] = 1'b1;
        wr_addr[1]  = 11'd7;
        wr_data[1]  = VEC_A;
        wr_strb[1]  = 8'h0F;
        #1;
        n_checks++;
        if (wr_ready !== 4'b0010 || ram_wen !== 1'b1) begin n_fail++; $display("FAIL wtr_wr_gnt: got %b wen=%b expected 0010 wen=1", wr_ready, ram_wen); end
        tick();
        clear_reqs();
        rd_valid[0] = 1'b1;
        rd_addr0[0] = 11'd7;
        rd_addr1[0] = 11'd7;
        #1;
        n_checks++;
        if (rd_ready !== 4'b0001) begin n_fail++; $display("FAIL wtr_rd_gnt: got %b expected 0001", rd_ready); end
        tick();
        clear_reqs();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_d0 !== VEC_MIX || rsp_d1 !== VEC_MIX) begin
            n_fail++; $display("FAIL wtr_data: got valid=%b id=%0d d0=%h d1=%h expected valid=1 id=0 %h", rsp_valid, rsp_id, rsp_d0, rsp_d1, VEC_MIX);
        end
        $display("txn write_then_read: d0=%h", rsp_d0);
    endtask

    task automatic test_collision();
        rd_valid[0] = 1'b1;
        rd_addr0[0] = 11'd7;
        rd_addr1[0] = 11'd3;
        wr_valid[3] = 1'b1;
        wr_addr[3]  = 11'd7;
        wr_data[3]  = VEC_C;
        wr_strb[3]  = 8'hFF;
        #1;
        n_checks++;
        if (rd_ready !== 4'b0001 || wr_ready !== 4'b0000 || ram_wen !== 1'b0) begin
            n_fail++; $display("FAIL col_first: got rd=%b wr=%b wen=%b expected rd=0001 wr=0000 wen=0", rd_ready, wr_ready, ram_wen);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_d0 !== VEC_MIX || rsp_d1 !== pattern(3)) begin
            n_fail++; $display("FAIL col_old_data: got valid=%b d0=%h d1=%h expected valid=1 %h/%h", rsp_valid, rsp_d0, rsp_d1, VEC_MIX, pattern(3));
        end
        n_checks++;
        if (dut.wr_starve_q !== 1'b1) begin n_fail++; $display("FAIL col_starve_set: got %b expected 1", dut.wr_starve_q); end
        #1;
        n_checks++;
        if (wr_ready !== 4'b1000 || rd_ready !== 4'b0000 || ram_wen !== 1'b1) begin
            n_fail++; $display("FAIL col_second: got rd=%b wr=%b wen=%b expected rd=0000 wr=1000 wen=1", rd_ready, wr_ready, ram_wen);
        end
        tick();
        wr_valid = '0;
        n_checks++;
        if (dut.wr_starve_q !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL col_starve_clr: got starve=%b rsp_valid=%b expected 0/0", dut.wr_starve_q, rsp_valid);
        end
        #1;
        n_checks++;
        if (rd_ready !== 4'b0001) begin n_fail++; $display("FAIL col_rd_retry: got %b expected 0001", rd_ready); end
        tick();
        clear_reqs();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_d0 !== VEC_C) begin n_fail++; $display("FAIL col_new_data: got valid=%b d0=%h expected valid=1 %h", rsp_valid, rsp_d0, VEC_C); end
        $display("txn collision: final d0=%h", rsp_d0);
    endtask

    task automatic test_back_to_back();
        rd_valid[2] = 1'b1;
        rd_addr0[2] = 11'd20;
        rd_addr1[2] = 11'd21;
        wr_valid[1] = 1'b1;
        wr_addr[1]  = 11'd100;
        wr_data[1]  = VEC_D;
        wr_strb[1]  = 8'hFF;
        #1;
        n_checks++;
        if (rd_ready !== 4'b0100 || wr_ready !== 4'b0010 || ram_wen !== 1'b1) begin
            n_fail++; $display("FAIL nocol_gnt: got rd=%b wr=%b wen=%b expected rd=0100 wr=0010 wen=1", rd_ready, wr_ready, ram_wen);
        end
        n_checks++;
        if (ram_waddr !== 11'd100 || ram_din !== VEC_D) begin n_fail++; $display("FAIL nocol_wport: got addr=%0d din=%h expected 100 %h", ram_waddr, ram_din, VEC_D); end
        tick();
        clear_reqs();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_d0 !== pattern(20) || rsp_d1 !== pattern(21)) begin
            n_fail++; $display("FAIL nocol_rsp: got valid=%b id=%0d d0=%h d1=%h expected 1 2 %h %h", rsp_valid, rsp_id, rsp_d0, rsp_d1, pattern(20), pattern(21));
        end
        rd_valid[2] = 1'b1;
        rd_addr0[2] = 11'd100;
        rd_addr1[2] = 11'd20;
        #1;
        n_checks++;
        if (rd_ready !== 4'b0100) begin n_fail++; $display("FAIL nocol_readback_gnt: got %b expected 0100", rd_ready); end
        tick();
        clear_reqs();
        n_checks++;
        if (rsp_d0 !== VEC_D) begin n_fail++; $display("FAIL nocol_readback: got %h expected %h", rsp_d0, VEC_D); end
        $display("txn back_to_back: readback d0=%h", rsp_d0);
    endtask

    task automatic test_reset_midop();
        rd_valid[3] = 1'b1;
        rd_addr0[3] = 11'd40;
        rd_addr1[3] = 11'd41;
        #1;
        n_checks++;
        if (rd_ready !== 4'b1000) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 1000", rd_ready); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin n_fail++; $display("FAIL midrst_rsp: got valid=%b id=%0d expected 1 3", rsp_valid, rsp_id); end
        rd_valid = 4'b1110;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL midrst_drop: got valid=%b id=%0d expected 0 0", rsp_valid, rsp_id); end
        n_checks++;
        if (rd_ready !== 4'b0000 || ram_wen !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt_off: got %b wen=%b expected 0000 wen=0", rd_ready, ram_wen); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rd_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_first_gnt: got %b expected 0010", rd_ready); end
        clear_reqs();
        tick();
        $display("txn reset_midop: done");
    endtask

    initial begin
        clear_reqs();
        for (int a = 0; a < 2048; a++) mem[a] = pattern(a);
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_collision();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
